mul_div_unit: RTL

// Parametrised multi-cycle RV32M multiply/divide unit; next generation of the single-cycle ALU.

---
 rtl/mul_div_unit.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Valid/ready handshake on both sides; divide-by-zero and signed overflow bypass the iteration.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    input  logic             kill_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] F_o,
    output logic             Zero_o,
    output logic             DivZero_o,
    output logic             Ov_o,
    output logic             busy_o
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_n;
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_op;
    logic               r_sign;
    logic [WIDTH:0]     r_acc;      // product high half / partial remainder
    logic [WIDTH-1:0]   r_lo;       // multiplier / dividend shifting into quotient
    logic [WIDTH-1:0]   r_opnd;     // multiplicand / divisor
    logic [WIDTH-1:0]   r_f;
    logic               r_zero;
    logic               r_divz;
    logic               r_ov;
    logic               r_ready;
    logic               r_valid;
    logic               r_busy;

    logic               w_accept;
    logic               w_a_neg;
    logic               w_b_neg;
    logic               w_sign;
    logic [WIDTH-1:0]   w_a_abs;
    logic [WIDTH-1:0]   w_b_abs;
    logic               w_b_zero;
    logic               w_ov_case;
    logic               w_fast;
    logic [WIDTH-1:0]   w_fast_res;
    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH:0]     w_acc_n;
    logic [WIDTH-1:0]   w_lo_n;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_c;
    logic [WIDTH-1:0]   w_quo_c;
    logic [WIDTH-1:0]   w_rem_c;
    logic [WIDTH-1:0]   w_calc_res;

    assign w_accept   = valid_i && r_ready && !kill_i;
    assign w_a_neg    = (~op_i[0] | (op_i == 3'b001)) & A_i[WIDTH-1];
    assign w_b_neg    = (op_i[2] ? ~op_i[0] : ~op_i[1]) & B_i[WIDTH-1];
    assign w_sign     = (op_i == 3'b110) ? w_a_neg : (w_a_neg ^ w_b_neg);
    assign w_a_abs    = w_a_neg ? ({WIDTH{1'b0}} - A_i) : A_i;
    assign w_b_abs    = w_b_neg ? ({WIDTH{1'b0}} - B_i) : B_i;
    assign w_b_zero   = (B_i == {WIDTH{1'b0}});
    assign w_ov_case  = op_i[2] & ~op_i[0] & (A_i == MIN_VAL) & (B_i == {WIDTH{1'b1}});
    assign w_fast     = op_i[2] & (w_b_zero | w_ov_case);
    assign w_fast_res = w_b_zero ? (op_i[1] ? A_i : {WIDTH{1'b1}})
                                 : (op_i[1] ? {WIDTH{1'b0}} : MIN_VAL);

    // One shift-add or restoring-subtract step on the shared datapath registers.
    always_comb begin
        w_add   = r_acc + (r_lo[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
        w_shift = {r_acc[WIDTH-1:0], r_lo[WIDTH-1]};
        w_diff  = w_shift - {1'b0, r_opnd};
        w_acc_n = r_acc;
        w_lo_n  = r_lo;
        if (!r_op[2]) begin
            w_acc_n = {1'b0, w_add[WIDTH:1]};
            w_lo_n  = {w_add[0], r_lo[WIDTH-1:1]};
        end else if (w_shift >= {1'b0, r_opnd}) begin
            w_acc_n = w_diff;
            w_lo_n  = {r_lo[WIDTH-2:0], 1'b1};
        end else begin
            w_acc_n = w_shift;
            w_lo_n  = {r_lo[WIDTH-2:0], 1'b0};
        end
    end

    // Sign-corrected result selection for the final iteration.
    always_comb begin
        w_prod   = {w_acc_n[WIDTH-1:0], w_lo_n};
        w_prod_c = r_sign ? ({(2*WIDTH){1'b0}} - w_prod) : w_prod;
        w_quo_c  = r_sign ? ({WIDTH{1'b0}} - w_lo_n) : w_lo_n;
        w_rem_c  = r_sign ? ({WIDTH{1'b0}} - w_acc_n[WIDTH-1:0]) : w_acc_n[WIDTH-1:0];
        case (r_op)
            3'b000:                 w_calc_res = w_prod_c[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: w_calc_res = w_prod_c[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         w_calc_res = w_quo_c;
            default:                w_calc_res = w_rem_c;
        endcase
    end

    // Next-state decode.
    always_comb begin
        w_state_n = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_n = w_fast ? S_DONE : S_CALC;
                else          w_state_n = S_IDLE;
            end
            S_CALC: begin
                if (kill_i)                         w_state_n = S_IDLE;
                else if (r_cnt == {CNT_W{1'b0}})    w_state_n = S_DONE;
                else                                w_state_n = S_CALC;
            end
            S_DONE: begin
                if (kill_i || ready_i) w_state_n = S_IDLE;
                else                   w_state_n = S_DONE;
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    // State register and handshake/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_ready <= (w_state_n == S_IDLE);
            r_valid <= (w_state_n == S_DONE);
            r_busy  <= (w_state_n != S_IDLE);
        end
    end

    // Operand capture, iteration and result/flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= {CNT_W{1'b0}};
            r_op   <= 3'b000;
            r_sign <= 1'b0;
            r_acc  <= {(WIDTH+1){1'b0}};
            r_lo   <= {WIDTH{1'b0}};
            r_opnd <= {WIDTH{1'b0}};
            r_f    <= {WIDTH{1'b0}};
            r_zero <= 1'b1;
            r_divz <= 1'b0;
            r_ov   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op   <= op_i;
                        r_sign <= w_sign;
                        r_acc  <= {(WIDTH+1){1'b0}};
                        r_lo   <= op_i[2] ? w_a_abs : w_b_abs;
                        r_opnd <= op_i[2] ? w_b_abs : w_a_abs;
                        r_cnt  <= CNT_W'(WIDTH - 1);
                        if (w_fast) begin
                            r_f    <= w_fast_res;
                            r_zero <= (w_fast_res == {WIDTH{1'b0}});
                            r_divz <= w_b_zero;
                            r_ov   <= ~w_b_zero;
                        end
                    end
                end
                S_CALC: begin
                    if (kill_i) begin
                        r_cnt <= {CNT_W{1'b0}};
                    end else begin
                        r_acc <= w_acc_n;
                        r_lo  <= w_lo_n;
                        if (r_cnt == {CNT_W{1'b0}}) begin
                            r_f    <= w_calc_res;
                            r_zero <= (w_calc_res == {WIDTH{1'b0}});
                            r_divz <= 1'b0;
                            r_ov   <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (kill_i || ready_i) begin
                        r_divz <= 1'b0;
                        r_ov   <= 1'b0;
                    end
                end
                default: begin
                    r_cnt <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign ready_o   = r_ready;
    assign valid_o   = r_valid;
    assign busy_o    = r_busy;
    assign F_o       = r_f;
    assign Zero_o    = r_zero;
    assign DivZero_o = r_divz;
    assign Ov_o      = r_ov;

endmodule
